// File: rtl/pte_fetch_unit_if.sv
// Walker-side PTE read port (pte_rd_if) and memory-side read bus (pte_mem_if) of pte_fetch_unit.
// Handshake: a beat transfers on a rising edge with valid & ready both high; a raised valid and its payload hold until then (mem_rsp_valid is a pulse with no ready).
interface pte_rd_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_pte;
    logic [1:0]  rsp_err;

    modport master (output req_valid, req_addr, rsp_ready,
                    input  req_ready, rsp_valid, rsp_pte, rsp_err);
    modport slave  (input  req_valid, req_addr, rsp_ready,
                    output req_ready, rsp_valid, rsp_pte, rsp_err);
endinterface

interface pte_mem_if #(
    parameter int PA_W = 56
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [PA_W-1:0] mem_addr;
    logic            mem_rsp_valid;
    logic [63:0]     mem_rsp_data;
    logic            mem_rsp_err;

    modport master (output mem_req_valid, mem_addr,
                    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err);
    modport slave  (input  mem_req_valid, mem_addr,
                    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err);
endinterface

// File: rtl/pte_fetch_unit.sv
// PTE read responder between the MMU walker and the data-memory arbiter: range/alignment check,
// single 64-bit memory read with timeout, optional PTE cache enabled by defining PTE_CACHE_EN.
module pte_fetch_unit #(
    parameter int PA_W          = 56,
    parameter int CACHE_ENTRIES = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    pte_rd_if.slave    walk,
    pte_mem_if.master  mem,
    output logic [2:0] dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MREQ  = 3'd1,
        S_MWAIT = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic            drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [63:0]     rsp_pte_q, rsp_pte_d;
    logic [1:0]      rsp_err_q, rsp_err_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [PA_W-1:0] mem_addr_q, mem_addr_d;

    logic            req_hs, rsp_hs, addr_bad, wait_last;
    logic            hit;
    logic [63:0]     hit_pte;

    // req_ready_q is only ever high while in IDLE, so it doubles as the IDLE qualifier.
    assign req_hs    = walk.req_valid & req_ready_q;
    assign rsp_hs    = rsp_valid_q & walk.rsp_ready;
    assign addr_bad  = (walk.req_addr[2:0] != 3'b000) || (walk.req_addr[63:PA_W] != '0);
    assign wait_last = (cnt_q == CNT_LAST);

`ifdef PTE_CACHE_EN
    localparam int PTR_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;

    logic [CACHE_ENTRIES-1:0] vld_q;
    logic [PA_W-4:0]          tag_q  [CACHE_ENTRIES];
    logic [63:0]              data_q [CACHE_ENTRIES];
    logic [PTR_W-1:0]         rr_q;
    logic                     nofill_q;
    logic                     fill_en;

    // A flush anywhere between acceptance and the response forbids caching that response.
    assign fill_en = (state_q == S_MWAIT) && mem.mem_rsp_valid && !mem.mem_rsp_err &&
                     mem.mem_rsp_data[0] && !nofill_q && !flush;

    always_comb begin
        hit     = 1'b0;
        hit_pte = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (vld_q[i] && (tag_q[i] == walk.req_addr[PA_W-1:3])) begin
                hit     = 1'b1;
                hit_pte = data_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            rr_q     <= '0;
            nofill_q <= 1'b0;
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (req_hs) begin
                nofill_q <= 1'b0;
            end else if (flush && (state_q == S_MREQ || state_q == S_MWAIT)) begin
                nofill_q <= 1'b1;
            end
            if (flush) begin
                vld_q <= '0;
            end else if (fill_en) begin
                vld_q[rr_q]  <= 1'b1;
                tag_q[rr_q]  <= mem_addr_q[PA_W-1:3];
                data_q[rr_q] <= mem.mem_rsp_data;
                rr_q         <= (rr_q == PTR_W'(CACHE_ENTRIES - 1)) ? '0 : rr_q + PTR_W'(1);
            end
        end
    end
`else
    logic unused_cfg;
    assign hit        = 1'b0;
    assign hit_pte    = '0;
    assign unused_cfg = flush ^ (CACHE_ENTRIES == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            drain_q         <= 1'b0;
            cnt_q           <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_pte_q       <= '0;
            rsp_err_q       <= 2'b00;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            drain_q         <= drain_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_pte_q       <= rsp_pte_d;
            rsp_err_q       <= rsp_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    state_d = (addr_bad || hit) ? S_RESP : S_MREQ;
                end
            end
            S_MREQ: begin
                if (mem.mem_req_ready) begin
                    state_d = S_MWAIT;
                    cnt_d   = '0;
                end
            end
            S_MWAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d = S_RESP;
                end else if (wait_last) begin
                    state_d = S_RESP;
                    drain_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                // A late response landing while still in RESP settles the drain here.
                if (drain_q && mem.mem_rsp_valid) begin
                    drain_d = 1'b0;
                end
                if (rsp_hs) begin
                    state_d = (drain_q && !mem.mem_rsp_valid) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem.mem_rsp_valid) begin
                    drain_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d     = (state_d == S_IDLE);
        rsp_valid_d     = (state_d == S_RESP);
        mem_req_valid_d = (state_d == S_MREQ);
        mem_addr_d      = req_hs ? walk.req_addr[PA_W-1:0] : mem_addr_q;
        rsp_pte_d       = rsp_pte_q;
        rsp_err_d       = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs && addr_bad) begin
                    rsp_pte_d = '0;
                    rsp_err_d = 2'b01;
                end else if (req_hs && hit) begin
                    rsp_pte_d = hit_pte;
                    rsp_err_d = 2'b00;
                end
            end
            S_MWAIT: begin
                if (mem.mem_rsp_valid) begin
                    rsp_pte_d = mem.mem_rsp_err ? 64'd0 : mem.mem_rsp_data;
                    rsp_err_d = mem.mem_rsp_err ? 2'b10 : 2'b00;
                end else if (wait_last) begin
                    rsp_pte_d = '0;
                    rsp_err_d = 2'b11;
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    rsp_pte_d = '0;
                    rsp_err_d = 2'b00;
                end
            end
            default: ;
        endcase
    end

    assign walk.req_ready    = req_ready_q;
    assign walk.rsp_valid    = rsp_valid_q;
    assign walk.rsp_pte      = rsp_pte_q;
    assign walk.rsp_err      = rsp_err_q;
    assign mem.mem_req_valid = mem_req_valid_q;
    assign mem.mem_addr      = mem_addr_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_pte_fetch_unit.sv
// Self-checking bench for pte_fetch_unit: walker driver, memory responder model and a response
// scoreboard; cache checks compile in when PTE_CACHE_EN is defined.
module tb_pte_fetch_unit;
    localparam int PA_W = 56;
    localparam int TMO  = 8;

    logic            clk, rst_n, flush;
    logic            req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0]     req_addr, rsp_pte;
    logic [1:0]      rsp_err;
    logic            mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_err;
    logic [PA_W-1:0] mem_addr;
    logic [63:0]     mem_rsp_data;
    logic [2:0]      dbg_state;

    pte_rd_if                 walk_if ();
    pte_mem_if #(.PA_W(PA_W)) mem_if ();

    assign walk_if.req_valid    = req_valid;
    assign walk_if.req_addr     = req_addr;
    assign walk_if.rsp_ready    = rsp_ready;
    assign req_ready            = walk_if.req_ready;
    assign rsp_valid            = walk_if.rsp_valid;
    assign rsp_pte              = walk_if.rsp_pte;
    assign rsp_err              = walk_if.rsp_err;
    assign mem_if.mem_req_ready = mem_req_ready;
    assign mem_if.mem_rsp_valid = mem_rsp_valid;
    assign mem_if.mem_rsp_data  = mem_rsp_data;
    assign mem_if.mem_rsp_err   = mem_rsp_err;
    assign mem_req_valid        = mem_if.mem_req_valid;
    assign mem_addr             = mem_if.mem_addr;

    pte_fetch_unit #(.PA_W(PA_W), .CACHE_ENTRIES(4), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .walk        (walk_if),
        .mem         (mem_if),
        .dbg_state_o (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [65:0]     exp_q[$];
    logic [PA_W-1:0] mem_exp_q[$];

    // memory model configuration, applied at the next memory handshake
    logic [63:0] cfg_data;
    logic        cfg_err;
    int          cfg_delay, cfg_stray, cfg_flush, stall_left;
    bit          flush_req;
    int          mem_hs_cnt = 0;
    int          mreq_cycles = 0;
    int          mem_acc_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mem_cfg(input logic [63:0] data, input logic err, input int delay,
                           input int stall, input int stray, input int flsh);
        cfg_data   = data;
        cfg_err    = err;
        cfg_delay  = delay;
        stall_left = stall;
        cfg_stray  = stray;
        cfg_flush  = flsh;
    endtask

    task automatic flush_pulse();
        flush_req = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Memory responder: inputs change on the falling edge, DUT samples them on the rising edge.
    initial begin
        int          rsp_cnt, stray_cnt, flush_cnt;
        logic [63:0] cur_data;
        logic        cur_err;
        rsp_cnt = 0; stray_cnt = 0; flush_cnt = 0; cur_data = '0; cur_err = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        flush = 1'b0; flush_req = 1'b0;
        mem_cfg(64'd0, 1'b0, 1, 0, 0, 0);
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0; flush = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rsp_valid = 1'b1; mem_rsp_data = cur_data; mem_rsp_err = cur_err;
                end
            end
            if (stray_cnt > 0) begin
                stray_cnt--;
                if (stray_cnt == 0) begin
                    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD1;
                end
            end
            if (flush_cnt > 0) begin
                flush_cnt--;
                if (flush_cnt == 0) flush = 1'b1;
            end
            if (flush_req) begin
                flush = 1'b1; flush_req = 1'b0;
            end
            if (mem_req_valid) mreq_cycles++;
            mem_req_ready = !(mem_req_valid && stall_left > 0);
            if (mem_req_valid && stall_left > 0) stall_left--;
            if (mem_req_valid && mem_req_ready) begin
                mem_hs_cnt++;
                mem_acc_cyc = cyc;
                check_eq("mem_req_expected", mem_exp_q.size() != 0, 1);
                if (mem_exp_q.size() != 0) check_eq("mem_addr", mem_addr, mem_exp_q.pop_front());
                rsp_cnt = cfg_delay; stray_cnt = cfg_stray; flush_cnt = cfg_flush;
                cur_data = cfg_data; cur_err = cfg_err;
            end
        end
    end

    // One walker transaction; lat is counted from request acceptance, or from the memory
    // handshake when lat_mem is set.
    task automatic transact(input logic [63:0] addr, input logic [1:0] err, input logic [63:0] pte,
                            input bit use_mem, input int lat, input bit lat_mem, input int hold,
                            input bit drain);
        int          n, t_acc, hs0, mc0;
        logic [65:0] e;
        hs0 = mem_hs_cnt;
        mc0 = mreq_cycles;
        exp_q.push_back({err, pte});
        if (use_mem) mem_exp_q.push_back(addr[PA_W-1:0]);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_accept", req_ready, 1);
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 64'($urandom);
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_valid_seen", rsp_valid, 1);
        check_eq("rsp_latency", cyc - (lat_mem ? mem_acc_cyc : t_acc), lat);
        e = exp_q.pop_front();
        check_eq("rsp_err_pte", {rsp_err, rsp_pte}, e);
        check_eq("req_ready_in_resp", req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", rsp_valid, 1);
            check_eq("hold_err_pte", {rsp_err, rsp_pte}, e);
            check_eq("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_after_hs", rsp_valid, 0);
        check_eq("req_ready_after_hs", req_ready, !drain);
        check_eq("mem_req_count", mem_hs_cnt - hs0, use_mem);
        if (!use_mem) check_eq("mem_req_valid_quiet", mreq_cycles - mc0, 0);
    endtask

    initial begin
        logic [63:0] a, d;
        logic        be;
        int          dl, st, c;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_req_ready", req_ready, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_pte", rsp_pte, 0);
        check_eq("reset_rsp_err", rsp_err, 0);
        check_eq("reset_mem_req_valid", mem_req_valid, 0);
        check_eq("reset_mem_addr", mem_addr, 0);
        check_eq("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("req_ready_after_reset", req_ready, 1);

        // aligned miss, then alignment and range errors
        mem_cfg(64'h2000_0C01, 1'b0, 1, 0, 0, 0);
        transact(64'h8000_1008, 2'b00, 64'h2000_0C01, 1, 3, 0, 0, 0);
        transact(64'h8000_1004, 2'b01, 64'd0, 0, 1, 0, 0, 0);
        transact(64'h0100_0000_0000_0000, 2'b01, 64'd0, 0, 1, 0, 0, 0);

        // bus error with a stalled walker
        mem_cfg(64'hDEAD_BEEF_0000_0001, 1'b1, 1, 0, 0, 0);
        transact(64'h8000_2000, 2'b10, 64'd0, 1, 3, 0, 5, 0);

        // memory request backpressure and slower response
        mem_cfg(64'h0000_0000_1234_5671, 1'b0, 3, 2, 0, 0);
        transact(64'h8000_3010, 2'b00, 64'h0000_0000_1234_5671, 1, 7, 0, 0, 0);

        // timeout, then a stray response three cycles later is drained
        mem_cfg(64'h0, 1'b0, 0, 0, TMO + 4, 0);
        transact(64'h8000_4000, 2'b11, 64'd0, 1, TMO + 1, 1, 0, 1);
        c = mem_acc_cyc;
        while (cyc < c + TMO + 5) begin
            @(negedge clk);
            check_eq("drain_req_ready", req_ready, cyc >= c + TMO + 5);
        end

        // randomised misses over distinct addresses
        for (int i = 0; i < 6; i++) begin
            a  = 64'h9000_0000 + 64'(i) * 64'h1000 + 64'($urandom_range(0, 511)) * 64'd8;
            d  = {32'($urandom), 32'($urandom)};
            be = ($urandom_range(0, 3) == 0);
            dl = $urandom_range(1, 4);
            st = $urandom_range(0, 2);
            mem_cfg(d, be, dl, st, 0, 0);
            transact(a, be ? 2'b10 : 2'b00, be ? 64'd0 : d, 1, 2 + st + dl, 0, 0, 0);
        end

        // flush while the memory read is outstanding still returns the data
        mem_cfg(64'h0000_0000_0000_0A01, 1'b0, 3, 0, 0, 1);
        transact(64'h8000_5008, 2'b00, 64'h0000_0000_0000_0A01, 1, 5, 0, 0, 0);

`ifdef PTE_CACHE_EN
        flush_pulse();
        mem_cfg(64'h2000_0C01, 1'b0, 1, 0, 0, 0);
        transact(64'h8000_1008, 2'b00, 64'h2000_0C01, 1, 3, 0, 0, 0);
        transact(64'h8000_1008, 2'b00, 64'h2000_0C01, 0, 1, 0, 0, 0);
        flush_pulse();
        transact(64'h8000_1008, 2'b00, 64'h2000_0C01, 1, 3, 0, 0, 0);

        // round-robin eviction with four entries
        flush_pulse();
        for (int k = 0; k < 5; k++) begin
            mem_cfg(64'h1000 + (64'(k) << 10) + 64'd1, 1'b0, 1, 0, 0, 0);
            transact(64'hA000_0000 + 64'(k) * 64'h40, 2'b00, 64'h1000 + (64'(k) << 10) + 64'd1, 1, 3, 0, 0, 0);
        end
        mem_cfg(64'h1001, 1'b0, 1, 0, 0, 0);
        transact(64'hA000_0000, 2'b00, 64'h1001, 1, 3, 0, 0, 0);
        transact(64'hA000_0100, 2'b00, 64'h1000 + (64'd4 << 10) + 64'd1, 0, 1, 0, 0, 0);

        // V=0 PTEs are never cached
        mem_cfg(64'h0000_0000_5555_0000, 1'b0, 1, 0, 0, 0);
        transact(64'hB000_0008, 2'b00, 64'h0000_0000_5555_0000, 1, 3, 0, 0, 0);
        transact(64'hB000_0008, 2'b00, 64'h0000_0000_5555_0000, 1, 3, 0, 0, 0);

        // the flush-during-MWAIT response above was not cached
        mem_cfg(64'h0000_0000_0000_0A01, 1'b0, 1, 0, 0, 0);
        transact(64'h8000_5008, 2'b00, 64'h0000_0000_0000_0A01, 1, 3, 0, 0, 0);
`else
        mem_cfg(64'h2000_0C01, 1'b0, 1, 0, 0, 0);
        transact(64'h8000_1008, 2'b00, 64'h2000_0C01, 1, 3, 0, 0, 0);
        flush_pulse();
        transact(64'h8000_1008, 2'b00, 64'h2000_0C01, 1, 3, 0, 0, 0);
`endif

        check_eq("scoreboard_empty", exp_q.size(), 0);
        check_eq("mem_queue_empty", mem_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
